// File: rtl/div_iter_4bit.sv
// Iterative restoring divider: one quotient bit per clock, MSB first.
// A valid/ready pair on each side; a zero divisor short-circuits straight
// to a result of all-ones quotient with the dividend as remainder.
module div_iter_4bit #(
   parameter int size = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [size-1:0] div_a,
   input  logic [size-1:0] div_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [size-1:0] quotient,
   output logic [size-1:0] remainder,
   output logic            div_zero
);

   localparam int               CNT_W = (size > 1) ? $clog2(size) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(size - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] step_cnt;
   logic [size-1:0]  dvd_sh;    // dividend, shifted left as bits are consumed
   logic [size-1:0]  dvs;       // latched divisor
   logic [size-1:0]  rem_acc;   // partial remainder
   logic [size-1:0]  quo_acc;   // quotient bits collected so far
   logic [size:0]    step_res;
   logic [size-1:0]  next_rem;
   logic             next_qbit;
   logic             accept;

   // One restoring step: returns {new partial remainder, quotient bit}.
   // The trial value is size+1 bits wide so the compare never overflows;
   // since rem < dvs, a successful difference always fits in size bits.
   function automatic logic [size:0] restore_step(
      input logic [size-1:0] rem,
      input logic            dvd_bit,
      input logic [size-1:0] dvs_v
   );
      logic [size:0] trial;
      logic [size:0] diff;
      trial = {rem, dvd_bit};
      diff  = trial - {1'b0, dvs_v};
      if (trial >= {1'b0, dvs_v})
         return {diff[size-1:0], 1'b1};
      else
         return {trial[size-1:0], 1'b0};
   endfunction

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && (state == IDLE);

   // Combinational step on the current partial remainder and next dividend bit.
   always_comb begin
      step_res = restore_step(rem_acc, dvd_sh[size-1], dvs);
   end

   assign next_rem  = step_res[size:1];
   assign next_qbit = step_res[0];

   // Datapath working registers: latch operands on accept, shift during CALC.
   always_ff @(posedge clk) begin
      if (accept) begin
         dvd_sh  <= div_a;
         dvs     <= div_b;
         rem_acc <= '0;
         quo_acc <= '0;
      end else if (state == CALC) begin
         dvd_sh  <= {dvd_sh[size-2:0], 1'b0};
         rem_acc <= next_rem;
         quo_acc <= {quo_acc[size-2:0], next_qbit};
      end
   end

   // Control FSM plus the registered result, which only changes on DONE entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         step_cnt  <= '0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (div_b == '0) begin
                     state     <= DONE;
                     quotient  <= '1;
                     remainder <= div_a;
                     div_zero  <= 1'b1;
                  end else begin
                     state    <= CALC;
                     step_cnt <= '0;
                  end
               end
            end
            CALC: begin
               step_cnt <= step_cnt + 1'b1;
               if (step_cnt == LAST) begin
                  state     <= DONE;
                  step_cnt  <= '0;
                  quotient  <= {quo_acc[size-2:0], next_qbit};
                  remainder <= next_rem;
                  div_zero  <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter_4bit.sv
// Directed and exhaustive bench for the iterative divider.
module tb_div_iter_4bit;

   localparam int SIZE = 4;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [SIZE-1:0] div_a;
   logic [SIZE-1:0] div_b;
   logic            out_valid;
   logic            out_ready;
   logic [SIZE-1:0] quotient;
   logic [SIZE-1:0] remainder;
   logic            div_zero;

   int vec_cnt;
   int err_cnt;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] q;
      logic [3:0] r;
      logic       z;
      int         hold;
   } vec_t;

   vec_t tbl [10];

   div_iter_4bit #(.size(SIZE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .div_a     (div_a),
      .div_b     (div_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count edges after the accept edge until out_valid is seen (bounded).
   // A zero divisor shows its result already right after the accept edge.
   task automatic wait_out(input logic noise, output int lat);
      lat = 0;
      while (!out_valid && lat < 3 * SIZE) begin
         chk("in_ready_busy", 32'(in_ready), 0);
         if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            div_a    = 4'($urandom);
            div_b    = 4'($urandom);
         end
         tick();
         lat++;
      end
      in_valid = 1'b0;
   endtask

   task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] q, input logic [3:0] r,
                         input logic z, input int hold, input int gap,
                         input logic noise);
      int n;
      int lat;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (gap) tick();
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      chk("in_ready_idle", 32'(in_ready), 1);
      in_valid = 1'b1;
      div_a    = a;
      div_b    = b;
      tick();
      in_valid = 1'b0;
      wait_out(noise, lat);
      chk("latency", lat, (b == 4'd0) ? 0 : SIZE);
      chk("quotient", 32'(quotient), 32'(q));
      chk("remainder", 32'(remainder), 32'(r));
      chk("div_zero", 32'(div_zero), 32'(z));
      for (int i = 0; i < hold; i++) begin
         if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            div_a    = 4'($urandom);
            div_b    = 4'($urandom);
         end
         tick();
         chk("hold_out_valid", 32'(out_valid), 1);
         chk("hold_quotient", 32'(quotient), 32'(q));
         chk("hold_remainder", 32'(remainder), 32'(r));
         chk("hold_in_ready", 32'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_after_take", 32'(out_valid), 0);
      chk("in_ready_after_take", 32'(in_ready), 1);
      chk("quotient_kept_idle", 32'(quotient), 32'(q));
   endtask

   initial begin
      int lat;
      logic [3:0] eq;
      logic [3:0] er;
      vec_cnt = 0;
      err_cnt = 0;

      tbl[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1,  z: 1'b0, hold: 0};
      tbl[1] = '{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7,  z: 1'b1, hold: 1};
      tbl[2] = '{a: 4'd14, b: 4'd3,  q: 4'd4,  r: 4'd2,  z: 1'b0, hold: 6};
      tbl[3] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0,  z: 1'b0, hold: 0};
      tbl[4] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0,  z: 1'b0, hold: 2};
      tbl[5] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0,  z: 1'b0, hold: 0};
      tbl[6] = '{a: 4'd1,  b: 4'd15, q: 4'd0,  r: 4'd1,  z: 1'b0, hold: 0};
      tbl[7] = '{a: 4'd0,  b: 4'd0,  q: 4'd15, r: 4'd0,  z: 1'b1, hold: 0};
      tbl[8] = '{a: 4'd8,  b: 4'd3,  q: 4'd2,  r: 4'd2,  z: 1'b0, hold: 3};
      tbl[9] = '{a: 4'd15, b: 4'd2,  q: 4'd7,  r: 4'd1,  z: 1'b0, hold: 0};

      // Reset with a zero-divisor pair already presented: nothing may be taken.
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      div_a     = 4'd7;
      div_b     = 4'd0;
      out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_quotient", 32'(quotient), 0);
      chk("rst_remainder", 32'(remainder), 0);
      chk("rst_div_zero", 32'(div_zero), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      rst_n = 1'b1;
      chk("release_no_accept", 32'(out_valid), 0);
      // First edge with reset high accepts 7/0; result present right after it.
      tick();
      in_valid = 1'b0;
      chk("first_accept_valid", 32'(out_valid), 1);
      chk("first_accept_q", 32'(quotient), 15);
      chk("first_accept_r", 32'(remainder), 7);
      chk("first_accept_z", 32'(div_zero), 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("first_take_idle", 32'(in_ready), 1);

      // Directed table.
      for (int i = 0; i < 10; i++)
         run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z,
                tbl[i].hold, i % 3, 1'b0);

      // Back-to-back with in_valid held: second pair waits for the first take.
      in_valid = 1'b1;
      div_a    = 4'd3;
      div_b    = 4'd9;
      tick();
      div_a = 4'd15;
      div_b = 4'd1;
      lat = 0;
      while (!out_valid && lat < 3 * SIZE) begin
         tick();
         lat++;
      end
      chk("b2b_lat1", lat, SIZE);
      chk("b2b_q1", 32'(quotient), 0);
      chk("b2b_r1", 32'(remainder), 3);
      chk("b2b_in_ready_done", 32'(in_ready), 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("b2b_idle_no_accept", 32'(in_ready), 1);
      chk("b2b_out_valid_low", 32'(out_valid), 0);
      tick();
      in_valid = 1'b0;
      chk("b2b_second_accept", 32'(in_ready), 0);
      lat = 0;
      while (!out_valid && lat < 3 * SIZE) begin
         div_a = 4'($urandom);
         div_b = 4'($urandom);
         tick();
         lat++;
      end
      chk("b2b_lat2", lat, SIZE);
      chk("b2b_q2", 32'(quotient), 15);
      chk("b2b_r2", 32'(remainder), 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset in the middle of CALC aborts the pair and clears the outputs.
      in_valid = 1'b1;
      div_a    = 4'd11;
      div_b    = 4'd2;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("abort_quotient", 32'(quotient), 0);
      chk("abort_remainder", 32'(remainder), 0);
      chk("abort_div_zero", 32'(div_zero), 0);
      chk("abort_out_valid", 32'(out_valid), 0);
      tick();
      rst_n = 1'b1;
      lat = 0;
      for (int i = 0; i < SIZE + 3; i++) begin
         tick();
         if (out_valid) lat++;
      end
      chk("abort_no_result", lat, 0);
      run_op(4'd9, 4'd4, 4'd2, 4'd1, 1'b0, 0, 0, 1'b0);

      // Every operand pair, with random idle gaps, hold times and input noise.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0) begin
               eq = 4'hF;
               er = 4'(a);
            end else begin
               eq = 4'(a / b);
               er = 4'(a % b);
            end
            run_op(4'(a), 4'(b), eq, er, (b == 0), $urandom_range(0, 3),
                   $urandom_range(0, 2), 1'b1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
